// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one synchronous single-port RAM between the three CPU memory
// clients: instruction fetch (read), load (read) and store (write). Every
// client uses a 4-phase req/ready handshake. Only one access runs at a time.
// Load has priority over fetch, and fetch has priority over store. The one
// exception is a store that has waited through STARVE_LIMIT consecutive read
// grants: that store is granted first.
//
// Ports
//   ram_clk                    single clock, all state on its rising edge
//   rst                        asynchronous reset, active low
//   fetch_read / _ready        fetch request / done (fetch_read_data valid)
//   fetch_read_address/_data   fetch address in, registered read data out
//   load_read / _ready         load request / done (load_read_data valid)
//   load_read_address/_data    load address in, registered read data out
//   store_save / _ready        store request / committed
//   store_save_address/_data   store address and write data in
//   ram_write_enable           one-cycle RAM write strobe
//   ram_address, ram_data_in   RAM address and write data (registered)
//   ram_data_out               RAM read data, valid RAM_LATENCY edges after
//                              the RAM samples the address

module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int RAM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              ram_clk,
    input  logic              rst,
    input  logic              fetch_read,
    output logic              fetch_read_ready,
    input  logic [ADDR_W-1:0] fetch_read_address,
    output logic [DATA_W-1:0] fetch_read_data,
    input  logic              load_read,
    output logic              load_read_ready,
    input  logic [ADDR_W-1:0] load_read_address,
    output logic [DATA_W-1:0] load_read_data,
    input  logic              store_save,
    output logic              store_save_ready,
    input  logic [ADDR_W-1:0] store_save_address,
    input  logic [DATA_W-1:0] store_save_data,
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESPOND = 2'd2} stateT;
    typedef enum logic [1:0] {CL_FETCH = 2'd0, CL_LOAD = 2'd1, CL_STORE = 2'd2} clientT;

    localparam logic [2:0] LAT_LAST   = 3'(RAM_LATENCY);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    stateT             state_q, state_d;
    clientT            client_q, client_d;
    logic [2:0]        latCnt_q, latCnt_d;
    logic [3:0]        starveCnt_q, starveCnt_d;
    logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
    logic              ramWe_q, ramWe_d;
    logic [DATA_W-1:0] ramWdata_q, ramWdata_d;
    logic [DATA_W-1:0] fetchData_q, fetchData_d;
    logic [DATA_W-1:0] loadData_q, loadData_d;
    logic              fetchRdy_q, fetchRdy_d;
    logic              loadRdy_q, loadRdy_d;
    logic              storeRdy_q, storeRdy_d;

    logic              grantValid;
    clientT            grantClient;
    logic              grantedReq;

    // Next-state logic. The IDLE branch picks at most one client per cycle.
    // A store whose starve counter has saturated wins over any read; otherwise
    // the order is load, fetch, store. The write strobe defaults to 0, so it
    // is high only in the cycle after a store grant. The access finishes when
    // the latency counter reaches RAM_LATENCY. If the client has dropped its
    // request by then, the access ends silently and the arbiter goes back to
    // IDLE. Read data is not captured in that case.
    always_comb begin
        state_d     = state_q;
        client_d    = client_q;
        latCnt_d    = latCnt_q;
        starveCnt_d = starveCnt_q;
        ramAddr_d   = ramAddr_q;
        ramWe_d     = 1'b0;
        ramWdata_d  = ramWdata_q;
        fetchData_d = fetchData_q;
        loadData_d  = loadData_q;
        fetchRdy_d  = fetchRdy_q;
        loadRdy_d   = loadRdy_q;
        storeRdy_d  = storeRdy_q;
        grantValid  = 1'b0;
        grantClient = CL_FETCH;
        grantedReq  = 1'b0;

        case (client_q)
            CL_FETCH: grantedReq = fetch_read;
            CL_LOAD:  grantedReq = load_read;
            CL_STORE: grantedReq = store_save;
            default:  grantedReq = 1'b0;
        endcase

        case (state_q)
            IDLE: begin
                if (store_save && (starveCnt_q == STARVE_MAX)) begin
                    grantValid  = 1'b1;
                    grantClient = CL_STORE;
                end else if (load_read) begin
                    grantValid  = 1'b1;
                    grantClient = CL_LOAD;
                end else if (fetch_read) begin
                    grantValid  = 1'b1;
                    grantClient = CL_FETCH;
                end else if (store_save) begin
                    grantValid  = 1'b1;
                    grantClient = CL_STORE;
                end

                if (!store_save) begin
                    starveCnt_d = '0;
                end else if (grantValid) begin
                    if (grantClient == CL_STORE) begin
                        starveCnt_d = '0;
                    end else if (starveCnt_q != STARVE_MAX) begin
                        starveCnt_d = starveCnt_q + 4'd1;
                    end
                end

                if (grantValid) begin
                    state_d  = ACCESS;
                    client_d = grantClient;
                    latCnt_d = '0;
                    case (grantClient)
                        CL_FETCH: ramAddr_d = fetch_read_address;
                        CL_LOAD:  ramAddr_d = load_read_address;
                        default: begin
                            ramAddr_d  = store_save_address;
                            ramWe_d    = 1'b1;
                            ramWdata_d = store_save_data;
                        end
                    endcase
                end
            end

            ACCESS: begin
                if (latCnt_q == LAT_LAST) begin
                    if (grantedReq) begin
                        state_d = RESPOND;
                        case (client_q)
                            CL_FETCH: begin
                                fetchRdy_d  = 1'b1;
                                fetchData_d = ram_data_out;
                            end
                            CL_LOAD: begin
                                loadRdy_d  = 1'b1;
                                loadData_d = ram_data_out;
                            end
                            default: storeRdy_d = 1'b1;
                        endcase
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    latCnt_d = latCnt_q + 3'd1;
                end
            end

            RESPOND: begin
                if (!grantedReq) begin
                    fetchRdy_d = 1'b0;
                    loadRdy_d  = 1'b0;
                    storeRdy_d = 1'b0;
                    state_d    = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers. A reset abandons any access in flight and
    // clears every output at once, including the write strobe.
    always_ff @(posedge ram_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            client_q    <= CL_FETCH;
            latCnt_q    <= '0;
            starveCnt_q <= '0;
            ramAddr_q   <= '0;
            ramWe_q     <= 1'b0;
            ramWdata_q  <= '0;
            fetchData_q <= '0;
            loadData_q  <= '0;
            fetchRdy_q  <= 1'b0;
            loadRdy_q   <= 1'b0;
            storeRdy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            client_q    <= client_d;
            latCnt_q    <= latCnt_d;
            starveCnt_q <= starveCnt_d;
            ramAddr_q   <= ramAddr_d;
            ramWe_q     <= ramWe_d;
            ramWdata_q  <= ramWdata_d;
            fetchData_q <= fetchData_d;
            loadData_q  <= loadData_d;
            fetchRdy_q  <= fetchRdy_d;
            loadRdy_q   <= loadRdy_d;
            storeRdy_q  <= storeRdy_d;
        end
    end

    assign fetch_read_ready = fetchRdy_q;
    assign fetch_read_data  = fetchData_q;
    assign load_read_ready  = loadRdy_q;
    assign load_read_data   = loadData_q;
    assign store_save_ready = storeRdy_q;
    assign ram_write_enable = ramWe_q;
    assign ram_address      = ramAddr_q;
    assign ram_data_in      = ramWdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Synthesizable, clocked responder for the three CPU memory clients: instruction fetch (read), load (read) and store (write).
- Accepts per-client 4-phase req/ready handshakes and serializes them onto one synchronous single-port RAM.
- Returns read data to the requesting client.
- Fixed priority with a starvation guard for the store port; sits between the pipeline stages and the RAM.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 8, data width
- RAM_LATENCY, 1, RAM clock edges from address sample to valid ram_data_out (1..4)
- STARVE_LIMIT, 3, consecutive read grants a pending store tolerates before forced grant (1..15)

Ports:
- ram_clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- fetch_read  in  1  fetch request
- fetch_read_ready  out  1  fetch done, fetch_read_data valid
- fetch_read_address  in  ADDR_W  fetch address
- fetch_read_data  out  DATA_W  fetch data
- load_read  in  1  load request
- load_read_ready  out  1  load done
- load_read_address  in  ADDR_W  load address
- load_read_data  out  DATA_W  load data
- store_save  in  1  store request
- store_save_ready  out  1  store committed
- store_save_address  in  ADDR_W  store address
- store_save_data  in  DATA_W  store data
- ram_write_enable  out  1  RAM write strobe
- ram_address  out  ADDR_W  RAM address
- ram_data_in  out  DATA_W  RAM write data
- ram_data_out  in  DATA_W  RAM read data

Behaviour:
- Reset (rst low, async): all outputs 0, state IDLE, latency counter 0, starve counter 0. Reset mid-access abandons it; ram_write_enable drops immediately; nothing is reported.
- Handshake per client:
  - Client raises req with address/data stable and holds them until ready.
  - Arbiter raises that client's ready once and holds it until req is sampled low.
  - Ready then falls on the next edge.
  - Read data is registered and stays valid while ready is high; afterwards it holds its last value.
- States:
  - IDLE: sample requests. On a grant, register ram_address; register ram_write_enable=1 plus ram_data_in for a store; go to ACCESS with counter=0.
  - ACCESS: ram_write_enable is high for exactly one cycle, then cleared. Counter increments each edge. When counter==RAM_LATENCY, capture ram_data_out into the client's data register (reads only), set that ready, go to RESPOND.
  - RESPOND: hold ready. When the granted req is sampled 0, clear ready and go to IDLE.
- Latency: grant at edge N; ready high after edge N+1+RAM_LATENCY for reads and writes alike.
- Minimum back-to-back spacing: req drop seen at edge M, ready low after M, next grant at edge M+1 at earliest.
- Priority in IDLE: load > fetch > store, except a pending store is granted first when starve counter == STARVE_LIMIT.
- Starve counter:
  - Increments on each read grant made while store_save is high.
  - Clears on a store grant or when store_save is low in IDLE.
  - Saturates at STARVE_LIMIT.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep req high and are re-evaluated in the next IDLE.
- Requests arriving during ACCESS/RESPOND are only sampled in IDLE. Addresses are captured at grant; later changes are ignored.
- Withdrawn request (req falls during ACCESS): access completes internally, with a store still committed to RAM. Ready is never asserted, and the arbiter returns to IDLE at the edge it would have entered RESPOND.
- Ready signals are mutually exclusive; at most one is high at any time.
- Address and data pass through unmodified, with no width conversion. ram_address holds its last value when idle.

Test Plan:
- Single fetch: RAM[0x0010]=0x01, fetch_read=1 addr 0x0010, RAM_LATENCY=1 -> fetch_read_ready high 2 edges after grant, fetch_read_data=0x01; ready held until fetch_read drops, low one edge later.
- Collision: load (0x0020, RAM=0xAA) and fetch (0x0000, RAM=0x03) raised same cycle -> load served first, returns 0xAA; fetch granted only after load handshake closes, returns 0x03; readies never overlap.
- Store then load-back: store 0x55 to 0x0100 -> ram_write_enable high exactly one cycle with address 0x0100, data 0x55, store_save_ready asserted. Then load 0x0100 -> 0x55.
- Starvation: store_save held high while fetch re-requests continuously, STARVE_LIMIT=3 -> exactly 3 fetch grants, then store granted before the 4th fetch.
- Withdrawal: load raised then dropped one edge after grant -> load_read_ready never rises; arbiter back in IDLE and serves a subsequent fetch normally.
- Async reset mid-store: rst low during ACCESS with ram_write_enable=1 -> ram_write_enable and all readies 0 immediately without a clock. After release, a fetch to 0x0004 completes with nominal latency.
